// File: rtl/pipeline_hazard_controller.sv
// Hazard/stall controller for a 5-stage pipeline: load-use and HI/LO interlocks,
// memory-wait freeze, HALT drain sequencing and a saturating stall-cycle counter.
module pipeline_hazard_controller #(
    parameter int MULDIV_LATENCY = 4,
    parameter int HALT_DRAIN     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_decode,
    input  logic [4:0]  rt_decode,
    input  logic [4:0]  write_reg_execute,
    input  logic        mem_to_reg_execute,
    input  logic        muldiv_start_execute,
    input  logic        hilo_read_decode,
    input  logic        mem_waitrequest,
    input  logic        HALT_decode,
    output logic        stall_fetch,
    output logic        stall_decode,
    output logic        stall_execute,
    output logic        stall_memory,
    output logic        flush_execute,
    output logic        halted,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_HALT_DRAIN, S_HALTED} state_t;

    localparam logic [5:0] MD_LOAD = 6'(MULDIV_LATENCY);
    localparam logic [3:0] DR_LOAD = 4'(HALT_DRAIN);

    state_t     state, state_next, ret_state, ret_next, eff;
    logic [5:0] md_cnt;
    logic [3:0] drain_cnt, drain_next;
    logic       load_use, hilo_stall, hazard;

    always_comb begin
        // Once a wait clears, MEM_WAIT behaves exactly like the state it froze.
        eff        = (state == S_MEM_WAIT) ? ret_state : state;
        load_use   = mem_to_reg_execute && (write_reg_execute != 5'd0) &&
                     ((write_reg_execute == rs_decode) || (write_reg_execute == rt_decode));
        hilo_stall = (md_cnt != 6'd0) && hilo_read_decode;
        hazard     = load_use || hilo_stall;

        stall_fetch   = 1'b0;
        stall_decode  = 1'b0;
        stall_execute = 1'b0;
        stall_memory  = 1'b0;
        flush_execute = 1'b0;
        halted        = 1'b0;
        state_next    = state;
        ret_next      = ret_state;
        drain_next    = drain_cnt;

        if (!reset) begin
            state_next = S_RUN;
        end else if (state == S_HALTED) begin
            {stall_fetch, stall_decode, stall_execute, stall_memory} = 4'b1111;
            halted = 1'b1;
        end else if (mem_waitrequest) begin
            {stall_fetch, stall_decode, stall_execute, stall_memory} = 4'b1111;
            state_next = S_MEM_WAIT;
            ret_next   = eff;
        end else if (eff == S_HALT_DRAIN) begin
            stall_fetch   = 1'b1;
            stall_decode  = 1'b1;
            flush_execute = 1'b1;
            drain_next    = (drain_cnt != 4'd0) ? drain_cnt - 4'd1 : 4'd0;
            state_next    = (drain_cnt <= 4'd1) ? S_HALTED : S_HALT_DRAIN;
        end else begin
            state_next = S_RUN;
            if (hazard) begin
                stall_fetch   = 1'b1;
                stall_decode  = 1'b1;
                flush_execute = 1'b1;
            end else if (HALT_decode) begin
                state_next = S_HALT_DRAIN;
                drain_next = DR_LOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_RUN;
            ret_state    <= S_RUN;
            md_cnt       <= 6'd0;
            drain_cnt    <= 4'd0;
            stall_cycles <= 32'd0;
        end else begin
            state     <= state_next;
            ret_state <= ret_next;
            drain_cnt <= drain_next;
            // A new start restarts the latency window even mid-count.
            if (muldiv_start_execute)
                md_cnt <= MD_LOAD;
            else if (md_cnt != 6'd0)
                md_cnt <= md_cnt - 6'd1;
            if (stall_fetch && (state != S_HALTED) && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have parameter MULDIV_LATENCY, default 4, meaning cycles from multiply/divide start until HI/LO are valid (legal range 1..63).
REQ-002 SHALL have parameter HALT_DRAIN, default 3, meaning cycles allowed for older instructions to retire after HALT reaches decode (legal range 1..15).
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous reset, active-low; sampled on the rising edge of clk.
REQ-005 SHALL have port rs_decode  in  5  source register rs of the decode-stage instruction.
REQ-006 SHALL have port rt_decode  in  5  source register rt of the decode-stage instruction.
REQ-007 SHALL have port write_reg_execute  in  5  destination register of the execute-stage instruction.
REQ-008 SHALL have port mem_to_reg_execute  in  1  the execute-stage instruction is a load.
REQ-009 SHALL have port muldiv_start_execute  in  1  single-cycle pulse: multiply/divide issued from execute.
REQ-010 SHALL have port hilo_read_decode  in  1  the decode-stage instruction reads HI/LO (MFHI/MFLO).
REQ-011 SHALL have port mem_waitrequest  in  1  data or instruction memory is not ready this cycle.
REQ-012 SHALL have port HALT_decode  in  1  HALT flag carried by the fetch/decode pipeline register.
REQ-013 SHALL have ports stall_fetch, stall_decode, stall_execute, stall_memory  out  1 each  1 = hold that stage's PC or pipeline register (drives its active-low enable directly).
REQ-014 SHALL have port flush_execute  out  1  1 = clear the decode/execute register (insert a bubble).
REQ-015 SHALL have port halted  out  1  the CPU has fully stopped.
REQ-016 SHALL have port stall_cycles  out  32  count of cycles in which stall_fetch was 1.

Function
REQ-017 SHALL implement FSM states RUN, MEM_WAIT, HALT_DRAIN and HALTED.
REQ-018 SHALL transition RUN->MEM_WAIT and HALT_DRAIN->MEM_WAIT when mem_waitrequest=1, with the return state recorded; MEM_WAIT SHALL return to the recorded state on the first cycle mem_waitrequest=0.
REQ-019 SHALL assert all four stall outputs combinationally, with flush_execute=0, in any cycle where mem_waitrequest=1 (regardless of state), so the whole pipeline freezes without losing instructions.
REQ-020 SHALL, in RUN when no wait is pending, detect load-use: mem_to_reg_execute=1, write_reg_execute!=0, and write_reg_execute equal to rs_decode or to rt_decode. On detection it SHALL assert stall_fetch=1, stall_decode=1 and flush_execute=1 in the same cycle, with stall_execute=0 and stall_memory=0.
REQ-021 SHALL hold a 6-bit muldiv counter: loaded to MULDIV_LATENCY on muldiv_start_execute=1, decremented by 1 each cycle while nonzero (including during MEM_WAIT), and never wrapping below 0.
REQ-022 SHALL, when the counter is nonzero and hilo_read_decode=1, assert stall_fetch, stall_decode and flush_execute, with the same effect as a load-use stall.
REQ-023 SHALL give a counter load priority over a decrement when start coincides with a nonzero count (restart).
REQ-024 SHALL apply this priority: mem_waitrequest > HI/LO stall > load-use; simultaneous HI/LO and load-use conditions produce one identical stall, not two.
REQ-025 SHALL transition RUN->HALT_DRAIN when HALT_decode=1 and no stall is asserted that cycle, load a drain counter with HALT_DRAIN, and keep stall_fetch=stall_decode=1 and flush_execute=1 throughout HALT_DRAIN.
REQ-026 SHALL decrement the drain counter only in cycles with mem_waitrequest=0, and enter HALTED when it reaches 0.
REQ-027 SHALL keep HALTED until reset: all stalls=1, flush_execute=0, halted=1, with mem_waitrequest ignored.
REQ-028 SHALL ignore HALT_decode in every state except RUN.
REQ-029 SHALL increment stall_cycles by 1 on every cycle with stall_fetch=1, except in HALTED, and saturate at 32'hFFFFFFFF.

Reset
REQ-030 SHALL, while reset=0 at a rising edge, set the state to RUN, both counters to 0 and stall_cycles to 0.
REQ-031 SHALL force all stall outputs, flush_execute and halted to 0 in any cycle where reset=0, including a reset taken mid-HALT_DRAIN or mid-MEM_WAIT.
REQ-032 SHALL take effect from a single low cycle, with no other events pending after reset.

Verification
REQ-033 SHALL cover load-use: write_reg_execute=5, mem_to_reg_execute=1, rt_decode=5 -> stall_fetch=stall_decode=flush_execute=1 for exactly 1 cycle; the same stimulus with write_reg_execute=0 -> no stall.
REQ-034 SHALL cover muldiv: a start pulse, then hilo_read_decode=1 from the next cycle -> stall for 4 cycles (count 4,3,2,1), released when the count reaches 0; stall_cycles=4.
REQ-035 SHALL cover memory wait during load-use: mem_waitrequest=1 for 3 cycles with a load-use condition present -> all stalls=1 and flush_execute=0 for 3 cycles, then the load-use stall resolves in 1 cycle.
REQ-036 SHALL cover halt: HALT_decode=1 in RUN -> 3 HALT_DRAIN cycles, then halted=1 permanently; one waitrequest cycle injected during drain -> halted rises 1 cycle later.
REQ-037 SHALL cover reset in HALT_DRAIN: reset=0 in the 2nd drain cycle -> all outputs 0, state RUN, stall_cycles=0 on the next edge.
REQ-038 SHALL cover restart: a second start pulse when the count is 2 -> count reloads to 4 and the HI/LO stall lengthens accordingly.
